// File: rtl/find_global_bkt_lvl_pipe.sv
// rtl/find_global_bkt_lvl_pipe.sv - pipelined downward scan of the lvls-states BRAM for the highest free level
//
// Walks levels from a clamped start level down to a floor, issuing one BRAM
// read per cycle. The first returned entry with has_bkt=0 is the hit: its level
// and bin are reported and the entry is rewritten with has_bkt=1.
//
// Optional feature macro: FIND_BKT_SCAN_CNT_EN adds scan_cnt_o (entries examined).
//
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   start_find             one-cycle start pulse, accepted only when idle
//   bkt_lvl_i, lvl_floor_i start level and floor level (both inclusive)
//   busy_o, apply_find_o   search in progress / BRAM port owned by this block
//   done_find, found_o     completion pulse and hit flag
//   bkt_lvl_o, bkt_bin_o   found level and its bin
//   ram_*_l_state_*        BRAM read/write port, entry = {bin_id, has_bkt}
//   scan_cnt_o             (FIND_BKT_SCAN_CNT_EN only) entries examined

module find_global_bkt_lvl_pipe #(
    parameter int WIDTH_LVL              = 16,
    parameter int WIDTH_BIN_ID           = 10,
    parameter int ADDR_WIDTH_LVLS_STATES = 9,
    parameter int RAM_RD_LAT             = 1,
    localparam int WIDTH_LVL_STATES      = WIDTH_BIN_ID + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_find,
    input  logic [WIDTH_LVL-1:0]              bkt_lvl_i,
    input  logic [WIDTH_LVL-1:0]              lvl_floor_i,
    output logic                              busy_o,
    output logic                              apply_find_o,
    output logic                              done_find,
    output logic                              found_o,
    output logic [WIDTH_LVL-1:0]              bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0]           bkt_bin_o,
    output logic                              ram_re_l_state_o,
    output logic                              ram_we_l_state_o,
    output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_addr_l_state_o,
    output logic [WIDTH_LVL_STATES-1:0]       ram_data_l_state_o,
    input  logic [WIDTH_LVL_STATES-1:0]       ram_data_l_state_i
`ifdef FIND_BKT_SCAN_CNT_EN
    ,
    output logic [WIDTH_LVL-1:0]              scan_cnt_o
`endif
);

    localparam logic [WIDTH_LVL-1:0] MAX_LVL = WIDTH_LVL'((1 << ADDR_WIDTH_LVLS_STATES) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state;
    logic [WIDTH_LVL-1:0]   issue_lvl;   // next level to read while scanning
    logic [WIDTH_LVL-1:0]   floor_lvl;
    logic [WIDTH_LVL-1:0]   rd_lvl;      // level of the read currently on the port

    // Read-tracking pipe: stage 0 captures the read on the port; the last stage
    // lines up with the cycle its data appears on ram_data_l_state_i.
    logic [RAM_RD_LAT-1:0]  pipe_vld;
    logic [WIDTH_LVL-1:0]   pipe_lvl [RAM_RD_LAT];

    logic                   ret_vld;
    logic                   ret_hit;
    logic                   pipe_empty;
    logic [WIDTH_LVL-1:0]   start_lvl;

    always_comb begin
        start_lvl  = (bkt_lvl_i > MAX_LVL) ? MAX_LVL : bkt_lvl_i;
        ret_vld    = pipe_vld[RAM_RD_LAT-1] && ((state == S_SCAN) || (state == S_DRAIN));
        ret_hit    = ret_vld && !ram_data_l_state_i[0];
        pipe_empty = (pipe_vld == '0) && !ram_re_l_state_o;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= S_IDLE;
            issue_lvl          <= '0;
            floor_lvl          <= '0;
            rd_lvl             <= '0;
            pipe_vld           <= '0;
            for (int i = 0; i < RAM_RD_LAT; i++) begin
                pipe_lvl[i] <= '0;
            end
            busy_o             <= 1'b0;
            apply_find_o       <= 1'b0;
            done_find          <= 1'b0;
            found_o            <= 1'b0;
            bkt_lvl_o          <= '0;
            bkt_bin_o          <= '0;
            ram_re_l_state_o   <= 1'b0;
            ram_we_l_state_o   <= 1'b0;
            ram_addr_l_state_o <= '0;
            ram_data_l_state_o <= '0;
`ifdef FIND_BKT_SCAN_CNT_EN
            scan_cnt_o         <= '0;
`endif
        end else begin
            for (int i = 1; i < RAM_RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_lvl[i] <= pipe_lvl[i-1];
            end
            pipe_vld[0] <= ram_re_l_state_o;
            pipe_lvl[0] <= rd_lvl;
            done_find   <= 1'b0;

`ifdef FIND_BKT_SCAN_CNT_EN
            if (ret_vld) begin
                scan_cnt_o <= scan_cnt_o + 1'b1;
            end
`endif

            if (ret_hit) begin
                // Descending issue order makes the first free return the highest
                // free level; later reads still in flight are discarded.
                pipe_vld           <= '0;
                ram_re_l_state_o   <= 1'b0;
                ram_we_l_state_o   <= 1'b1;
                ram_addr_l_state_o <= pipe_lvl[RAM_RD_LAT-1][ADDR_WIDTH_LVLS_STATES-1:0];
                ram_data_l_state_o <= {ram_data_l_state_i[WIDTH_LVL_STATES-1:1], 1'b1};
                bkt_lvl_o          <= pipe_lvl[RAM_RD_LAT-1];
                bkt_bin_o          <= ram_data_l_state_i[WIDTH_LVL_STATES-1:1];
                found_o            <= 1'b1;
                state              <= S_WRITE;
            end else begin
                case (state)
                    S_IDLE: begin
                        ram_re_l_state_o <= 1'b0;
                        ram_we_l_state_o <= 1'b0;
                        if (start_find) begin
                            busy_o    <= 1'b1;
                            found_o   <= 1'b0;
                            bkt_lvl_o <= '0;
                            bkt_bin_o <= '0;
                            floor_lvl <= lvl_floor_i;
`ifdef FIND_BKT_SCAN_CNT_EN
                            scan_cnt_o <= '0;
`endif
                            if (start_lvl < lvl_floor_i) begin
                                done_find <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                // First read goes out directly so it lands in cycle 1.
                                apply_find_o       <= 1'b1;
                                ram_re_l_state_o   <= 1'b1;
                                ram_addr_l_state_o <= start_lvl[ADDR_WIDTH_LVLS_STATES-1:0];
                                rd_lvl             <= start_lvl;
                                issue_lvl          <= start_lvl - 1'b1;
                                state              <= (start_lvl == lvl_floor_i) ? S_DRAIN : S_SCAN;
                            end
                        end
                    end
                    S_SCAN: begin
                        ram_re_l_state_o   <= 1'b1;
                        ram_addr_l_state_o <= issue_lvl[ADDR_WIDTH_LVLS_STATES-1:0];
                        rd_lvl             <= issue_lvl;
                        // Stop at the floor rather than decrementing, so floor 0 never wraps.
                        if (issue_lvl == floor_lvl) begin
                            state <= S_DRAIN;
                        end else begin
                            issue_lvl <= issue_lvl - 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        ram_re_l_state_o <= 1'b0;
                        if (pipe_empty) begin
                            apply_find_o <= 1'b0;
                            done_find    <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                    S_WRITE: begin
                        ram_we_l_state_o <= 1'b0;
                        apply_find_o     <= 1'b0;
                        done_find        <= 1'b1;
                        state            <= S_DONE;
                    end
                    S_DONE: begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
